tdes_pass_sequencer: RTL and testbench

Sequences one Triple-DES operation (EDE) over a shared single-DES round core. Sits directly downstream of the AHB-Lite slave controller: it consumes `enable`, `encryption_type`, `data` and `key1..key3`, and returns the 64-bit result on `output_data`, which the controller reads back as `HRDATA`. It runs three DES passes back-to-back. It latches operands at start and drives the DES core through a start/done handshake.

---
 rtl/tdes_pass_sequencer.sv | 168 ++++++++++++++++
 tb/tb_tdes_pass_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdes_pass_sequencer.sv
// Triple-DES (EDE) pass sequencer: latches operands on an enable rising edge and
// drives three back-to-back passes through a shared single-DES core.
module tdes_pass_sequencer (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        enable,
    input  logic        encryption_type,
    input  logic [63:0] data,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    output logic        des_start,
    output logic        des_decrypt,
    output logic [63:0] des_key,
    output logic [63:0] des_in,
    input  logic [63:0] des_out,
    input  logic        des_done,
    output logic [63:0] output_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  pass_r;
    logic [1:0]  pass_s;
    logic [63:0] blk_r;
    logic [63:0] blk_s;
    logic [63:0] output_data_r;
    logic [63:0] output_data_s;
    logic [63:0] key1_r;
    logic [63:0] key2_r;
    logic [63:0] key3_r;
    logic        mode_r;
    logic        enable_d_r;
    logic        load_s;
    logic        start_s;
    logic        des_start_r;
    logic        busy_r;
    logic        done_r;

    // Encrypt runs key1,key2,key3; decrypt runs the same keys in reverse order.
    function automatic logic [63:0] sched_key(input logic [1:0] p, input logic m,
                                              input logic [63:0] k1, input logic [63:0] k2,
                                              input logic [63:0] k3);
        logic [63:0] k;
        case (p)
            2'd0:    k = m ? k3 : k1;
            2'd1:    k = k2;
            2'd2:    k = m ? k1 : k3;
            default: k = 64'd0;
        endcase
        return k;
    endfunction

    // The middle pass always runs opposite to the requested direction.
    function automatic logic sched_decrypt(input logic [1:0] p, input logic m);
        return m ^ (p == 2'd1);
    endfunction

    assign start_s = enable & ~enable_d_r;

    // Next-state and datapath update logic.
    always_comb begin
        state_s       = state_r;
        pass_s        = pass_r;
        blk_s         = blk_r;
        output_data_s = output_data_r;
        load_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    pass_s  = 2'd0;
                    blk_s   = data;
                    load_s  = 1'b1;
                    state_s = ST_LAUNCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (des_done) begin
                    blk_s = des_out;
                    if (pass_r == 2'd2) begin
                        output_data_s = des_out;
                        state_s       = ST_DONE;
                    end else begin
                        pass_s  = pass_r + 2'd1;
                        state_s = ST_LAUNCH;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, operand and registered control-output storage.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_r       <= ST_IDLE;
            pass_r        <= 2'd0;
            blk_r         <= 64'd0;
            output_data_r <= 64'd0;
            key1_r        <= 64'd0;
            key2_r        <= 64'd0;
            key3_r        <= 64'd0;
            mode_r        <= 1'b0;
            enable_d_r    <= 1'b0;
            des_start_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            pass_r        <= pass_s;
            blk_r         <= blk_s;
            output_data_r <= output_data_s;
            enable_d_r    <= enable;
            if (load_s) begin
                key1_r <= key1;
                key2_r <= key2;
                key3_r <= key3;
                mode_r <= encryption_type;
            end
            des_start_r <= (state_s == ST_LAUNCH);
            busy_r      <= (state_s == ST_LAUNCH) || (state_s == ST_WAIT);
            done_r      <= (state_s == ST_DONE);
        end
    end

    // Core-facing operands; held at zero while idle.
    always_comb begin
        des_key     = 64'd0;
        des_in      = 64'd0;
        des_decrypt = 1'b0;
        if (state_r != ST_IDLE) begin
            des_key     = sched_key(pass_r, mode_r, key1_r, key2_r, key3_r);
            des_in      = blk_r;
            des_decrypt = sched_decrypt(pass_r, mode_r);
        end else begin
            des_key     = 64'd0;
            des_in      = 64'd0;
            des_decrypt = 1'b0;
        end
    end

    assign des_start   = des_start_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign output_data = output_data_r;

endmodule

// File: tb/tb_tdes_pass_sequencer.sv
// Randomized bench for tdes_pass_sequencer with a behavioural DES-core stub and a
// pass-schedule reference model.
module tb_tdes_pass_sequencer;

    logic        HCLK;
    logic        HRESET;
    logic        enable;
    logic        encryption_type;
    logic [63:0] data, key1, key2, key3;
    logic        des_start, des_decrypt;
    logic [63:0] des_key, des_in, des_out, output_data;
    logic        des_done, busy, done;

    int total = 0;
    int bad   = 0;
    int lat   = 16;

    logic [63:0] cap_key [64];
    logic [63:0] cap_in  [64];
    logic        cap_dec [64];
    int          cap_total = 0;
    int          spur_cnt  = 0;
    logic [63:0] spur_val  = 64'd0;

    tdes_pass_sequencer dut (
        .HCLK(HCLK), .HRESET(HRESET), .enable(enable), .encryption_type(encryption_type),
        .data(data), .key1(key1), .key2(key2), .key3(key3),
        .des_start(des_start), .des_decrypt(des_decrypt), .des_key(des_key), .des_in(des_in),
        .des_out(des_out), .des_done(des_done), .output_data(output_data),
        .busy(busy), .done(done)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Direction-sensitive, order-sensitive stand-in for one DES pass.
    function automatic logic [63:0] core_f(input logic [63:0] x, input logic [63:0] k, input logic d);
        return {x[62:0], x[63]} ^ k ^ (d ? 64'hA5A5_5A5A_0F0F_F0F0 : 64'd0);
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Core stub: answers each des_start after lat cycles; can also inject a stray des_done.
    initial begin
        int cnt;
        int spur_seen;
        logic [63:0] pin, pkey;
        logic pdec;
        cnt = 0; spur_seen = 0; pin = 64'd0; pkey = 64'd0; pdec = 1'b0;
        des_done = 1'b0;
        des_out  = 64'd0;
        forever begin
            @(posedge HCLK);
            #1;
            des_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    des_done = 1'b1;
                    des_out  = core_f(pin, pkey, pdec);
                end
            end else if (spur_seen != spur_cnt) begin
                spur_seen = spur_cnt;
                des_done  = 1'b1;
                des_out   = spur_val;
            end
            if (des_start === 1'b1) begin
                pin  = des_in;
                pkey = des_key;
                pdec = des_decrypt;
                cap_in[cap_total % 64]  = des_in;
                cap_key[cap_total % 64] = des_key;
                cap_dec[cap_total % 64] = des_decrypt;
                cap_total++;
                cnt = lat;
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    // kind: 0 plain, 1 change operands at cycle 5, 2 re-pulse enable at cycle 10
    task automatic run_op(input string name, input logic [63:0] d, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] c, input logic m,
                          input int l, input int kind);
        logic [63:0] ekey [3];
        logic        edec [3];
        logic [63:0] ein  [3];
        logic [63:0] blk, res;
        int base, rel, dcyc, busy_bad;
        ekey[0] = m ? c : a; ekey[1] = b; ekey[2] = m ? a : c;
        edec[0] = m; edec[1] = ~m; edec[2] = m;
        blk = d;
        for (int i = 0; i < 3; i++) begin
            ein[i] = blk;
            blk = core_f(blk, ekey[i], edec[i]);
        end
        enable = 1'b0;
        tick();
        lat  = l;
        base = cap_total;
        data = d; key1 = a; key2 = b; key3 = c; encryption_type = m;
        enable = 1'b1;
        rel = 0; dcyc = -1; busy_bad = -1; res = 64'd0;
        while (rel < 3 * l + 20 && dcyc < 0) begin
            tick();
            rel++;
            if (busy !== (rel <= 3 * l + 3) && busy_bad < 0) busy_bad = rel;
            if (done === 1'b1) begin
                dcyc = rel;
                res  = output_data;
            end
            if (rel == 2) enable = 1'b0;
            if (kind == 1 && rel == 5) begin
                data = rnd64(); key1 = rnd64(); key2 = rnd64(); key3 = rnd64();
                encryption_type = ~m;
            end
            if (kind == 2 && rel == 10) enable = 1'b1;
            if (kind == 2 && rel == 11) enable = 1'b0;
        end
        total++;
        if (dcyc < 0) begin
            bad++;
            $display("FAIL %s timeout: no done within %0d cycles", name, 3 * l + 20);
            return;
        end
        total++;
        if (dcyc != 3 * l + 4) begin
            bad++;
            $display("FAIL %s done_cycle got=%0d exp=%0d", name, dcyc, 3 * l + 4);
        end
        total++;
        if (busy_bad >= 0) begin
            bad++;
            $display("FAIL %s busy wrong at cycle %0d got=%b exp=%b", name, busy_bad,
                     ~(busy_bad <= 3 * l + 3), (busy_bad <= 3 * l + 3));
        end
        total++;
        if (cap_total - base != 3) begin
            bad++;
            $display("FAIL %s pass_count got=%0d exp=3", name, cap_total - base);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (cap_key[(base + i) % 64] !== ekey[i]) begin
                bad++;
                $display("FAIL %s des_key[%0d] got=%h exp=%h", name, i, cap_key[(base + i) % 64], ekey[i]);
            end
            total++;
            if (cap_dec[(base + i) % 64] !== edec[i]) begin
                bad++;
                $display("FAIL %s des_decrypt[%0d] got=%b exp=%b", name, i, cap_dec[(base + i) % 64], edec[i]);
            end
            total++;
            if (cap_in[(base + i) % 64] !== ein[i]) begin
                bad++;
                $display("FAIL %s des_in[%0d] got=%h exp=%h", name, i, cap_in[(base + i) % 64], ein[i]);
            end
        end
        total++;
        if (res !== blk) begin
            bad++;
            $display("FAIL %s output_data got=%h exp=%h", name, res, blk);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || output_data !== blk) begin
            bad++;
            $display("FAIL %s after_done done=%b busy=%b out=%h exp 0,0,%h", name, done, busy, output_data, blk);
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b0; enable = 1'b0; encryption_type = 1'b0;
        data = 64'd0; key1 = 64'd0; key2 = 64'd0; key3 = 64'd0;
        repeat (3) tick();
        total++;
        if ({des_start, des_decrypt, busy, done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0000", {des_start, des_decrypt, busy, done});
        end
        total++;
        if ({des_key, des_in, output_data} !== 192'd0) begin
            bad++;
            $display("FAIL reset_data key=%h in=%h out=%h exp all 0", des_key, des_in, output_data);
        end
        HRESET = 1'b1;
        tick();
    endtask

    task automatic test_schedule();
        for (int i = 0; i < 6; i++)
            run_op("schedule", rnd64(), rnd64(), rnd64(), rnd64(), i[0], 16, 0);
    endtask

    task automatic test_isolation();
        run_op("isolation_enc", rnd64(), rnd64(), rnd64(), rnd64(), 1'b0, 6, 1);
        run_op("isolation_dec", rnd64(), rnd64(), rnd64(), rnd64(), 1'b1, 6, 1);
    endtask

    task automatic test_enable_pulse();
        int base;
        int seen;
        base = cap_total;
        run_op("enable_pulse", rnd64(), rnd64(), rnd64(), rnd64(), 1'b0, 16, 2);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (busy === 1'b1 || des_start === 1'b1) seen++;
        end
        total++;
        if (seen != 0 || cap_total - base != 3) begin
            bad++;
            $display("FAIL enable_pulse_second_op busy_cycles=%0d passes=%0d exp 0 and 3", seen, cap_total - base);
        end
    endtask

    task automatic test_enable_hold();
        int dones;
        enable = 1'b0;
        tick();
        lat = 4;
        data = rnd64(); key1 = rnd64(); key2 = rnd64(); key3 = rnd64(); encryption_type = 1'b0;
        enable = 1'b1;
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        enable = 1'b0;
        tick();
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL enable_hold done_count got=%0d exp=1", dones);
        end
    endtask

    task automatic test_spurious_done();
        logic [63:0] prev;
        int odd;
        tick();
        prev = output_data;
        spur_val = rnd64();
        spur_cnt++;
        odd = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0 || des_start !== 1'b0 || output_data !== prev) odd++;
        end
        total++;
        if (odd != 0) begin
            bad++;
            $display("FAIL spurious_done disturbed_cycles got=%0d exp=0 out=%h exp_out=%h", odd, output_data, prev);
        end
    endtask

    task automatic test_reset_mid();
        int odd;
        enable = 1'b0;
        tick();
        lat = 8;
        data = rnd64(); key1 = rnd64(); key2 = rnd64(); key3 = rnd64(); encryption_type = 1'b1;
        enable = 1'b1;
        for (int rel = 1; rel <= 12; rel++) begin
            tick();
            if (rel == 2) enable = 1'b0;
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_precondition busy got=%b exp=1", busy);
        end
        HRESET = 1'b0;
        #1;
        total++;
        if ({des_start, des_decrypt, busy, done} !== 4'b0000 ||
            {des_key, des_in, output_data} !== 192'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs ctrl=%b key=%h in=%h out=%h exp all 0",
                     {des_start, des_decrypt, busy, done}, des_key, des_in, output_data);
        end
        #2;
        HRESET = 1'b1;
        odd = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0 || des_start !== 1'b0 || output_data !== 64'd0) odd++;
        end
        total++;
        if (odd != 0) begin
            bad++;
            $display("FAIL reset_mid_late_des_done disturbed_cycles got=%0d exp=0", odd);
        end
        run_op("reset_mid_fresh", rnd64(), rnd64(), rnd64(), rnd64(), 1'b0, 8, 0);
    endtask

    task automatic test_latency_sweep();
        run_op("latency_1", rnd64(), rnd64(), rnd64(), rnd64(), 1'b0, 1, 0);
        run_op("latency_2", rnd64(), rnd64(), rnd64(), rnd64(), 1'b1, 2, 0);
        run_op("latency_40", rnd64(), rnd64(), rnd64(), rnd64(), 1'b0, 40, 0);
    endtask

    initial begin
        test_reset();
        test_schedule();
        test_isolation();
        test_enable_pulse();
        test_enable_hold();
        test_spurious_done();
        test_reset_mid();
        test_latency_sweep();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            run_op("back_to_back", rnd64(), rnd64(), rnd64(), rnd64(), $urandom_range(1, 0) == 1, 3, 0);
    endtask

endmodule
